// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO word packer.
package fifo_pkg;

    // Widest lane count the keep helper can describe.
    localparam int unsigned MAX_PACK = 32;

    // Flush sequencing states.
    typedef enum logic [1:0] {
        COLLECT    = 2'd0,
        FLUSH_WAIT = 2'd1,
        FLUSH_EMIT = 2'd2
    } flush_state_e;

    // Lane-keep mask with the lowest 'fill' bits set.
    function automatic logic [MAX_PACK-1:0] keep_mask(input logic [31:0] fill);
        logic [MAX_PACK-1:0] mask;
        mask = {MAX_PACK{1'b0}};
        for (int i = 0; i < MAX_PACK; i++) begin
            mask[i] = (32'(i) < fill);
        end
        return mask;
    endfunction

endpackage

// File: rtl/out_word_reg.sv
// Single-entry valid/ready holding register for a packed word and its sideband.
module out_word_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [KEEP_WIDTH-1:0] load_keep,
    input  logic                  load_last,
    input  logic                  accept,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [KEEP_WIDTH-1:0] keep,
    output logic                  last,
    output logic                  empty
);

    logic                  valid_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [KEEP_WIDTH-1:0] keep_r;
    logic                  last_r;

    // Load a new word, drop valid on acceptance, otherwise hold the contents stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_WIDTH{1'b0}};
            keep_r  <= {KEEP_WIDTH{1'b0}};
            last_r  <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
            keep_r  <= load_keep;
            last_r  <= load_last;
        end else if (valid_r && accept) begin
            valid_r <= 1'b0;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;
    assign keep  = keep_r;
    assign last  = last_r;
    assign empty = !valid_r;

endmodule

// File: rtl/fifo_word_packer.sv
// Drains a narrow FIFO and packs PACK consecutive entries into one wide
// valid/ready word; a flush forces out a partial word with a keep mask.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]        fifo_dout,
    input  logic                         fifo_empty,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH*PACK-1:0]   out_data,
    output logic [PACK-1:0]              out_keep,
    output logic                         out_last,
    output logic                         flush_busy
);

    localparam int OUT_WIDTH = DATA_WIDTH * PACK;
    localparam int FW        = $clog2(PACK + 1);

    localparam logic [FW-1:0] FILL_ZERO = FW'(0);
    localparam logic [FW-1:0] FILL_LAST = FW'(PACK - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(PACK);
    localparam logic [FW:0]   OCC_FULL  = (FW + 1)'(PACK);

    logic [FW-1:0]         fill_r;
    logic                  inflight_r;
    logic                  flush_req_r;
    flush_state_e          state_r;
    flush_state_e          state_next_s;
    logic [DATA_WIDTH-1:0] lane_r [PACK];

    logic [FW:0]           occupancy_s;
    logic                  rd_en_s;
    logic                  cap_s;
    logic                  out_empty_s;
    logic                  out_free_s;
    logic                  flush_acc_s;
    logic                  full_ready_s;
    logic                  load_full_s;
    logic                  load_part_s;
    logic                  load_s;
    logic                  load_last_s;
    logic [PACK-1:0]       load_keep_s;
    logic [OUT_WIDTH-1:0]  asm_s;
    logic [OUT_WIDTH-1:0]  keep_bits_s;
    logic [OUT_WIDTH-1:0]  load_data_s;

    // A byte returned by the FIFO is present whenever a read was issued last cycle.
    assign cap_s = inflight_r;

    // Issue a read only when a lane is guaranteed for it and no flush is draining.
    always_comb begin
        occupancy_s = {1'b0, fill_r} + {{FW{1'b0}}, inflight_r};
        rd_en_s     = !rst && !fifo_empty && !flush_req_r && (occupancy_s < OCC_FULL);
    end

    assign fifo_rd_en = rd_en_s;

    // Assembly view: stored lanes with the arriving byte merged into its lane.
    always_comb begin
        asm_s = {OUT_WIDTH{1'b0}};
        for (int i = 0; i < PACK; i++) begin
            if (cap_s && (fill_r == FW'(i))) begin
                asm_s[i*DATA_WIDTH +: DATA_WIDTH] = fifo_dout;
            end else begin
                asm_s[i*DATA_WIDTH +: DATA_WIDTH] = lane_r[i];
            end
        end
    end

    // Decide when the output register is loaded, and with which keep/last.
    always_comb begin
        out_free_s   = out_empty_s || out_ready;
        flush_acc_s  = flush && (state_r == COLLECT);
        full_ready_s = (cap_s && (fill_r == FILL_LAST)) || (!cap_s && (fill_r == FILL_FULL));
        load_full_s  = full_ready_s && out_free_s;
        load_part_s  = (state_r == FLUSH_EMIT) && !cap_s && (fill_r != FILL_ZERO)
                       && (fill_r < FILL_FULL) && out_free_s;
        load_s       = load_full_s || load_part_s;
        // A word closed while a flush is pending or arriving is the flushed tail.
        load_last_s  = load_part_s || flush_req_r || flush_acc_s;
        if (load_full_s) begin
            load_keep_s = {PACK{1'b1}};
        end else begin
            load_keep_s = PACK'(keep_mask(32'(fill_r)));
        end
    end

    // Zero the unused lanes of a partial word.
    always_comb begin
        keep_bits_s = {OUT_WIDTH{1'b0}};
        for (int i = 0; i < PACK; i++) begin
            keep_bits_s[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{load_keep_s[i]}};
        end
        load_data_s = asm_s & keep_bits_s;
    end

    // Track the outstanding read and the number of filled lanes.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_r     <= FILL_ZERO;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= rd_en_s;
            if (load_s) begin
                fill_r <= FILL_ZERO;
            end else if (cap_s) begin
                fill_r <= fill_r + FW'(1);
            end
        end
    end

    // Store an arriving byte into the next lane unless it goes straight out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PACK; i++) begin
                lane_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < PACK; i++) begin
                if (cap_s && !load_s && (fill_r == FW'(i))) begin
                    lane_r[i] <= fifo_dout;
                end
            end
        end
    end

    // Flush state register; flush_req mirrors any non-collecting state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= COLLECT;
            flush_req_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            flush_req_r <= (state_next_s != COLLECT);
        end
    end

    // Flush sequencing: let the in-flight byte land, then emit whatever is pending.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            COLLECT: begin
                if (flush) begin
                    state_next_s = FLUSH_WAIT;
                end else begin
                    state_next_s = COLLECT;
                end
            end
            FLUSH_WAIT: begin
                if (!inflight_r) begin
                    state_next_s = FLUSH_EMIT;
                end else begin
                    state_next_s = FLUSH_WAIT;
                end
            end
            FLUSH_EMIT: begin
                if ((fill_r == FILL_ZERO) || out_free_s) begin
                    state_next_s = COLLECT;
                end else begin
                    state_next_s = FLUSH_EMIT;
                end
            end
            default: begin
                state_next_s = COLLECT;
            end
        endcase
    end

    assign flush_busy = flush_req_r;

    out_word_reg #(
        .DATA_WIDTH (OUT_WIDTH),
        .KEEP_WIDTH (PACK)
    ) u_out_word_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .load_data (load_data_s),
        .load_keep (load_keep_s),
        .load_last (load_last_s),
        .accept    (out_ready),
        .valid     (out_valid),
        .data      (out_data),
        .keep      (out_keep),
        .last      (out_last),
        .empty     (out_empty_s)
    );

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a behavioural FIFO and a word scoreboard.
module tb_fifo_word_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_rd_en;
    logic [7:0]  fifo_dout = 8'h00;
    logic        fifo_empty;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        flush_busy;

    always #5 clk = ~clk;

    fifo_word_packer #(.DATA_WIDTH(8), .PACK(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .flush_busy (flush_busy)
    );

    // Behavioural FIFO with one-cycle read latency.
    logic [7:0] mem [0:255];
    int wr_cnt = 0;
    int rd_cnt = 0;
    assign fifo_empty = (wr_cnt == rd_cnt);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[rd_cnt[7:0]];
            rd_cnt    <= rd_cnt + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [31:0] cyc;
    } word_t;

    word_t obs_q[$];
    word_t exp_q[$];

    // Record every accepted output word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            obs_q.push_back({out_data, out_keep, out_last, 32'(cyc)});
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wr_cnt[7:0]] = b;
        wr_cnt++;
    endtask

    task automatic exp_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_q.push_back({d, k, l, 32'd0});
    endtask

    task automatic take_word(input string tag, output logic [31:0] c);
        word_t o;
        word_t e;
        int    n;
        n = 0;
        c = 32'd0;
        while (obs_q.size() == 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_arrive"}, 32'(obs_q.size() != 0), 32'd1);
        if (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_data"}, o.data, e.data);
            chk({tag, "_keep"}, 32'(o.keep), 32'(e.keep));
            chk({tag, "_last"}, 32'(o.last), 32'(e.last));
            c = o.cyc;
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          cnt;
        logic        busy_early;
        logic [31:0] c0;
        logic [31:0] c1;

        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset with the FIFO preloaded: nothing may be read or presented.
        for (int b = 1; b <= 8; b++) push_byte(8'(b));
        exp_word(32'h04030201, 4'hF, 1'b0);
        exp_word(32'h08070605, 4'hF, 1'b0);
        tick();
        tick();
        @(negedge clk);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  out_data, 32'd0);
        chk("rst_keep",  32'(out_keep), 32'd0);
        chk("rst_last",  32'(out_last), 32'd0);
        chk("rst_busy",  32'(flush_busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming: first read to first valid is PACK+1 cycles.
        @(negedge clk);
        chk("first_rd_en", 32'(fifo_rd_en), 32'd1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'd5);
        take_word("stream_w0", c0);
        take_word("stream_w1", c1);
        repeat (3) tick();
        @(negedge clk);
        chk("drained_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("drained_valid", 32'(out_valid), 32'd0);

        // Partial word flush of three bytes.
        tick();
        push_byte(8'hAA);
        push_byte(8'hBB);
        push_byte(8'hCC);
        repeat (8) tick();
        exp_word(32'h00CCBBAA, 4'h7, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy_set", 32'(flush_busy), 32'd1);
        busy_early = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
            if (!out_valid && !flush_busy) busy_early = 1'b1;
        end
        chk("flush_busy_held", 32'(busy_early), 32'd0);
        chk("flush_busy_clear_on_load", 32'(flush_busy), 32'd0);
        take_word("partial", c0);

        // Flush with nothing pending: no word, busy clears quickly.
        repeat (2) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        n = 1;
        while (flush_busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("empty_flush_clear", 32'(n <= 3), 32'd1);
        repeat (4) tick();
        chk("empty_flush_no_word", 32'(obs_q.size()), 32'd0);

        // Backpressure: first word held, second assembled, reads stop.
        out_ready = 1'b0;
        for (int b = 16; b < 24; b++) push_byte(8'(b));
        exp_word(32'h13121110, 4'hF, 1'b0);
        exp_word(32'h17161514, 4'hF, 1'b0);
        repeat (6) tick();
        @(negedge clk);
        chk("stall_early_data", out_data, 32'h13121110);
        repeat (14) tick();
        @(negedge clk);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data",  out_data, 32'h13121110);
        chk("stall_keep",  32'(out_keep), 32'hF);
        chk("stall_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("stall_fifo_drained", 32'(rd_cnt == wr_cnt), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        take_word("release_w0", c0);
        take_word("release_w1", c1);
        chk("back_to_back", c1 - c0, 32'd1);

        // Flush while the fourth byte is in flight closes a full word as last.
        repeat (3) tick();
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        exp_word(32'h44332211, 4'hF, 1'b1);
        cnt = 0;
        n = 0;
        while (cnt < 4 && n < 20) begin
            @(negedge clk);
            n++;
            if (fifo_rd_en) cnt++;
        end
        chk("late_flush_reads", 32'(cnt), 32'd4);
        @(posedge clk);
        #1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        take_word("late_flush", c0);
        repeat (5) tick();
        chk("late_flush_busy_idle", 32'(flush_busy), 32'd0);
        chk("late_flush_no_extra", 32'(obs_q.size()), 32'd0);

        // Reset mid-word discards captured bytes; next word is fresh.
        push_byte(8'h55);
        push_byte(8'h66);
        repeat (5) tick();
        push_byte(8'h77);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_data",  out_data, 32'd0);
        chk("midrst_keep",  32'(out_keep), 32'd0);
        chk("midrst_last",  32'(out_last), 32'd0);
        push_byte(8'h71);
        push_byte(8'h72);
        push_byte(8'h73);
        exp_word(32'h73727177, 4'hF, 1'b0);
        take_word("fresh", c0);

        repeat (4) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("no_unexpected_words", 32'(obs_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
